// File: rtl/qspi_flash_responder.sv
// qspi_flash_responder: QSPI NOR-flash target that maps controller commands onto a byte-wide memory port
// Ports: clk/rst system clock and sync active-high reset; f_cs/f_sclk/f_dq_i async flash pads;
// f_dq_o/f_dq_oe pad drive and per-line enable; mem_addr/mem_rd_en/mem_rdata/mem_wr_en/mem_wdata/mem_erase
// byte memory port (rdata valid 1 clk after rd_en); busy mirrors the WIP status bit.
module qspi_flash_responder #(
    parameter logic [23:0] JEDEC_ID = 24'h20BA18,
    parameter int PROG_CYCLES = 1024,
    parameter int ERASE_CYCLES = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_cs,
    input  logic        f_sclk,
    input  logic [3:0]  f_dq_i,
    output logic [3:0]  f_dq_o,
    output logic [3:0]  f_dq_oe,
    output logic [23:0] mem_addr,
    output logic        mem_rd_en,
    input  logic [7:0]  mem_rdata,
    output logic        mem_wr_en,
    output logic [7:0]  mem_wdata,
    output logic        mem_erase,
    output logic        busy
);
    typedef enum logic [3:0] {IDLE, CMD, ADDR, DUMMY, RD_DATA, WR_DATA, STATUS, ID, IGNORE} state_t;
    state_t state;
    logic [1:0] cs_s, sclk_s;
    logic [3:0] dq_m, dq;
    logic cs_d, sclk_d, quad, wr_any, erase_arm, wel, wip, rd_q;
    logic [4:0] cnt;
    logic [7:0] sh_in, sh_out, cmd, ptr, rbuf, op, ld, nb, id_byte;
    logic [1:0] idx;
    logic [23:0] addr, full;
    logic [31:0] wip_cnt;
    logic rise, fall, cs_rise, cs_fall, wip_eff, out_st;
    assign busy = wip;
    always_comb begin
        rise = sclk_s[1] & ~sclk_d;
        fall = ~sclk_s[1] & sclk_d;
        cs_rise = cs_s[1] & ~cs_d;
        cs_fall = ~cs_s[1] & cs_d;
        // a counter expiring this clk no longer blocks a command decoded on the same clk
        wip_eff = wip & (wip_cnt != 32'd1);
        op = {sh_in[6:0], dq[0]};
        full = {addr[22:0], dq[0]};
        id_byte = idx == 2'd0 ? JEDEC_ID[23:16] : idx == 2'd1 ? JEDEC_ID[15:8] : idx == 2'd2 ? JEDEC_ID[7:0] : 8'h00;
        ld = state == STATUS ? {6'b0, wel, wip} : state == ID ? id_byte : rbuf;
        nb = cnt == 5'd0 ? ld : sh_out;
        out_st = state == RD_DATA || state == STATUS || state == ID;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_s <= 2'b11;
            sclk_s <= 2'b00;
            dq_m <= '0;
            dq <= '0;
            cs_d <= 1'b1;
            sclk_d <= 1'b0;
            state <= IDLE;
            cnt <= '0;
            sh_in <= '0;
            sh_out <= '0;
            cmd <= '0;
            addr <= '0;
            ptr <= '0;
            idx <= '0;
            quad <= 1'b0;
            wr_any <= 1'b0;
            erase_arm <= 1'b0;
            wel <= 1'b0;
            wip <= 1'b0;
            wip_cnt <= '0;
            rd_q <= 1'b0;
            rbuf <= '0;
            f_dq_o <= '0;
            f_dq_oe <= '0;
            mem_addr <= '0;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_wdata <= '0;
            mem_erase <= 1'b0;
        end else begin
            cs_s <= {cs_s[0], f_cs};
            sclk_s <= {sclk_s[0], f_sclk};
            dq_m <= f_dq_i;
            dq <= dq_m;
            cs_d <= cs_s[1];
            sclk_d <= sclk_s[1];
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_erase <= 1'b0;
            rd_q <= mem_rd_en;
            if (rd_q) rbuf <= mem_rdata;
            if (wip) begin
                wip_cnt <= wip_cnt - 32'd1;
                if (wip_cnt == 32'd1) wip <= 1'b0;
            end
            if (cs_rise) begin
                state <= IDLE;
                f_dq_oe <= '0;
                f_dq_o <= '0;
                cnt <= '0;
                wel <= cmd == 8'h06 ? 1'b1 : (cmd == 8'h04 || wr_any || erase_arm) ? 1'b0 : wel;
                if (wr_any || erase_arm) begin
                    wip <= 1'b1;
                    wip_cnt <= 32'(erase_arm ? ERASE_CYCLES : PROG_CYCLES);
                end
                if (erase_arm) begin
                    mem_erase <= 1'b1;
                    mem_addr <= {addr[23:12], 12'h000};
                end
                wr_any <= 1'b0;
                erase_arm <= 1'b0;
            end else if (cs_fall) begin
                state <= CMD;
                cnt <= '0;
                cmd <= '0;
                quad <= 1'b0;
                idx <= '0;
                wr_any <= 1'b0;
                erase_arm <= 1'b0;
            end else if (rise) begin
                case (state)
                    CMD: begin
                        sh_in <= op;
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd7) begin
                            cnt <= '0;
                            // a rejected opcode is recorded as 0x00 so cs rise has no side effect
                            cmd <= (wip_eff && op != 8'h05) ? 8'h00 : op;
                            if (wip_eff && op != 8'h05) state <= IGNORE;
                            else case (op)
                                8'h05, 8'h9F: begin
                                    state <= op == 8'h05 ? STATUS : ID;
                                    f_dq_oe <= 4'b0010;
                                end
                                8'h03, 8'h6B: state <= ADDR;
                                8'h32, 8'h20: state <= wel ? ADDR : IGNORE;
                                default: state <= IGNORE;
                            endcase
                        end
                    end
                    ADDR: begin
                        addr <= full;
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd23) begin
                            cnt <= '0;
                            case (cmd)
                                8'h03, 8'h6B: begin
                                    state <= cmd == 8'h03 ? RD_DATA : DUMMY;
                                    f_dq_oe <= cmd == 8'h03 ? 4'b0010 : 4'b0000;
                                    quad <= cmd == 8'h6B;
                                    mem_addr <= full;
                                    mem_rd_en <= 1'b1;
                                end
                                8'h32: begin
                                    state <= WR_DATA;
                                    ptr <= full[7:0];
                                end
                                default: begin
                                    state <= IGNORE;
                                    erase_arm <= 1'b1;
                                end
                            endcase
                        end
                    end
                    DUMMY: begin
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd7) begin
                            cnt <= '0;
                            state <= RD_DATA;
                            f_dq_oe <= 4'b1111;
                        end
                    end
                    WR_DATA: begin
                        sh_in <= {sh_in[3:0], dq};
                        cnt <= {4'b0, ~cnt[0]};
                        if (cnt[0]) begin
                            mem_wr_en <= 1'b1;
                            mem_wdata <= {sh_in[3:0], dq};
                            mem_addr <= {addr[23:8], ptr};
                            ptr <= ptr + 8'd1;
                            wr_any <= 1'b1;
                        end
                    end
                    // any bit past the 32nd disqualifies a pending erase
                    IGNORE: erase_arm <= 1'b0;
                    default: ;
                endcase
            end else if (fall && out_st) begin
                if (quad) begin
                    f_dq_o <= nb[7:4];
                    sh_out <= {nb[3:0], 4'h0};
                    cnt <= {4'b0, ~cnt[0]};
                end else begin
                    f_dq_o <= {2'b0, nb[7], 1'b0};
                    sh_out <= {nb[6:0], 1'b0};
                    cnt <= cnt == 5'd7 ? 5'd0 : cnt + 5'd1;
                end
                // each byte load prefetches the next address so rbuf is ready a byte ahead
                if (cnt == 5'd0 && state == RD_DATA) begin
                    mem_rd_en <= 1'b1;
                    mem_addr <= mem_addr + 24'd1;
                end
                if (cnt == 5'd0 && state == ID && idx != 2'd3) idx <= idx + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_qspi_flash_responder.sv
// tb_qspi_flash_responder: directed and randomized self-checking bench for qspi_flash_responder
module tb_qspi_flash_responder;
    localparam int PROG = 300;
    localparam int ERASE = 1500;
    localparam int HALF = 6;
    logic clk = 1'b0, rst = 1'b1, f_cs = 1'b1, f_sclk = 1'b0;
    logic [3:0] f_dq_i = 4'h0, f_dq_o, f_dq_oe;
    logic [23:0] mem_addr;
    logic mem_rd_en, mem_wr_en, mem_erase, busy;
    logic [7:0] mem_rdata, mem_wdata;
    logic [7:0] key = 8'h00;
    int total = 0, bad = 0, busy_len = 0;
    logic [23:0] rdq[$];
    logic [23:0] erq[$];
    logic [31:0] wrq[$];

    qspi_flash_responder #(.PROG_CYCLES(PROG), .ERASE_CYCLES(ERASE)) dut (
        .clk(clk), .rst(rst), .f_cs(f_cs), .f_sclk(f_sclk), .f_dq_i(f_dq_i),
        .f_dq_o(f_dq_o), .f_dq_oe(f_dq_oe), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
        .mem_rdata(mem_rdata), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
        .mem_erase(mem_erase), .busy(busy)
    );

    always #5 clk = ~clk;

    // memory model: byte at address A is A[7:0]^key, returned one clk after the strobe
    always @(posedge clk) begin
        if (rst) mem_rdata <= 8'h00;
        else if (mem_rd_en) mem_rdata <= mem_addr[7:0] ^ key;
        if (mem_rd_en) rdq.push_back(mem_addr);
        if (mem_wr_en) wrq.push_back({mem_addr, mem_wdata});
        if (mem_erase) erq.push_back(mem_addr);
        if (busy) busy_len <= busy_len + 1;
    end

    initial begin
        #1000000;
        $fatal(1, "FAIL watchdog timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bitx(input logic [3:0] d, output logic [3:0] q, output logic [3:0] oe);
        f_dq_i = d;
        clks(HALF);
        q = f_dq_o;
        oe = f_dq_oe;
        f_sclk = 1'b1;
        clks(HALF);
        f_sclk = 1'b0;
    endtask

    task automatic cs_on;
        f_cs = 1'b0;
        clks(HALF);
    endtask

    task automatic cs_off;
        clks(HALF);
        f_cs = 1'b1;
        f_dq_i = 4'h0;
        clks(4 * HALF);
    endtask

    task automatic tx(input logic [31:0] v, input int n);
        logic [3:0] q, oe;
        for (int i = n - 1; i >= 0; i--) bitx({3'b000, v[i]}, q, oe);
    endtask

    task automatic txq(input logic [7:0] v);
        logic [3:0] q, oe;
        bitx(v[7:4], q, oe);
        bitx(v[3:0], q, oe);
    endtask

    task automatic rx1(output logic [7:0] b, output logic [3:0] oor, output logic [3:0] oand);
        logic [3:0] q, oe;
        oor = 4'h0;
        oand = 4'hF;
        for (int i = 7; i >= 0; i--) begin
            bitx(4'h0, q, oe);
            b[i] = q[1];
            oor |= oe;
            oand &= oe;
        end
    endtask

    task automatic rxq(output logic [7:0] b, output logic [3:0] oor, output logic [3:0] oand);
        logic [3:0] q1, q2, o1, o2;
        bitx(4'h0, q1, o1);
        bitx(4'h0, q2, o2);
        b = {q1, q2};
        oor = o1 | o2;
        oand = o1 & o2;
    endtask

    task automatic cmd1(input logic [7:0] op);
        cs_on;
        tx(32'(op), 8);
        cs_off;
    endtask

    task automatic rdsr(output logic [7:0] s);
        logic [3:0] x, y;
        cs_on;
        tx(32'h05, 8);
        rx1(s, x, y);
        cs_off;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 20000) begin
            clks(1);
            n++;
        end
        chk(tag, 32'(busy), 32'h0);
    endtask

    initial begin
        logic [7:0] b;
        logic [3:0] oor, oand, q, o;
        logic [23:0] a;
        logic [7:0] pd [8];
        logic [7:0] idv [4];
        logic [7:0] pv [4];
        int rb, wb, eb, bl, n, qd;
        idv = '{8'h20, 8'hBA, 8'h18, 8'h00};
        pv = '{8'h11, 8'h22, 8'h33, 8'h44};
        clks(3);
        chk("rst_dq_o", 32'(f_dq_o), 32'h0);
        chk("rst_oe", 32'(f_dq_oe), 32'h0);
        chk("rst_addr", 32'(mem_addr), 32'h0);
        chk("rst_strobes", 32'({mem_rd_en, mem_wr_en, mem_erase}), 32'h0);
        chk("rst_wdata", 32'(mem_wdata), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        clks(4);
        cs_on;
        tx(32'h9F, 8);
        for (int i = 0; i < 4; i++) begin
            rx1(b, oor, oand);
            chk("rdid_byte", 32'(b), 32'(idv[i]));
            chk("rdid_oe", 32'({oor, oand}), 32'h22);
        end
        cs_off;
        chk("rdid_oe_off", 32'(f_dq_oe), 32'h0);
        wb = wrq.size();
        cs_on;
        tx(32'h32, 8);
        tx(32'h000100, 24);
        txq(8'hA5);
        cs_off;
        chk("nowren_writes", 32'(wrq.size() - wb), 32'h0);
        rdsr(b);
        chk("nowren_sr", 32'(b), 32'h00);
        cmd1(8'h06);
        rdsr(b);
        chk("wren_sr", 32'(b), 32'h02);
        wb = wrq.size();
        bl = busy_len;
        cs_on;
        tx(32'h32, 8);
        tx(32'h0001FE, 24);
        for (int i = 0; i < 4; i++) txq(pv[i]);
        cs_off;
        chk("prog_count", 32'(wrq.size() - wb), 32'd4);
        a = 24'h0001FE;
        for (int i = 0; i < 4; i++) chk("prog_wr", wrq[wb + i], {a[23:8], 8'(a[7:0] + 8'(i)), pv[i]});
        rdsr(b);
        chk("prog_sr_busy", 32'(b), 32'h01);
        wait_idle("prog_wait");
        chk("prog_busy_len", 32'(busy_len - bl), 32'(PROG));
        rdsr(b);
        chk("prog_sr_done", 32'(b), 32'h00);
        key = 8'h00;
        rb = rdq.size();
        cs_on;
        tx(32'h6B, 8);
        tx(32'hFFFFFF, 24);
        tx(32'h0, 8);
        rxq(b, oor, oand);
        chk("qrd_b0", 32'(b), 32'hFF);
        chk("qrd_oe", 32'({oor, oand}), 32'hFF);
        rxq(b, oor, oand);
        chk("qrd_b1", 32'(b), 32'h00);
        cs_off;
        chk("qrd_addr0", 32'(rdq[rb]), 32'hFFFFFF);
        chk("qrd_addr1", 32'(rdq[rb + 1]), 32'h000000);
        chk("qrd_oe_off", 32'(f_dq_oe), 32'h0);
        cmd1(8'h06);
        eb = erq.size();
        bl = busy_len;
        cs_on;
        tx(32'h20, 8);
        tx(32'h012345, 24);
        cs_off;
        chk("erase_count", 32'(erq.size() - eb), 32'd1);
        chk("erase_addr", 32'(erq[eb]), 32'h012000);
        chk("erase_busy", 32'(busy), 32'h1);
        rb = rdq.size();
        cs_on;
        tx(32'h03, 8);
        tx(32'h000010, 24);
        rx1(b, oor, oand);
        cs_off;
        chk("busy_read_oe", 32'(oor), 32'h0);
        chk("busy_read_strobes", 32'(rdq.size() - rb), 32'h0);
        cmd1(8'h06);
        wait_idle("erase_wait");
        chk("erase_busy_len", 32'(busy_len - bl), 32'(ERASE));
        rdsr(b);
        chk("erase_sr_done", 32'(b), 32'h00);
        cmd1(8'h06);
        eb = erq.size();
        cs_on;
        tx(32'h20, 8);
        tx(32'hABCDE, 20);
        cs_off;
        chk("abort_erase", 32'(erq.size() - eb), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        rdsr(b);
        chk("abort_sr", 32'(b), 32'h02);
        cmd1(8'h04);
        rdsr(b);
        chk("wrdi_sr", 32'(b), 32'h00);
        for (int it = 0; it < 4; it++) begin
            a = 24'($urandom);
            key = 8'($urandom);
            n = $urandom_range(2, 4);
            qd = $urandom_range(0, 1);
            rb = rdq.size();
            cs_on;
            tx(qd != 0 ? 32'h6B : 32'h03, 8);
            tx(32'(a), 24);
            if (qd != 0) tx(32'h0, 8);
            for (int i = 0; i < n; i++) begin
                if (qd != 0) rxq(b, oor, oand);
                else rx1(b, oor, oand);
                chk("rnd_rd", 32'(b), 32'(8'(a + 24'(i)) ^ key));
            end
            cs_off;
            chk("rnd_rd_addr", 32'(rdq[rb]), 32'(a));
        end
        for (int it = 0; it < 3; it++) begin
            cmd1(8'h06);
            a = 24'($urandom);
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) pd[i] = 8'($urandom);
            wb = wrq.size();
            cs_on;
            tx(32'h32, 8);
            tx(32'(a), 24);
            for (int i = 0; i < n; i++) txq(pd[i]);
            bitx(4'h7, q, o);
            cs_off;
            chk("rnd_prog_count", 32'(wrq.size() - wb), 32'(n));
            for (int i = 0; i < n; i++) chk("rnd_prog_wr", wrq[wb + i], {a[23:8], 8'(a[7:0] + 8'(i)), pd[i]});
            wait_idle("rnd_prog_wait");
        end
        cmd1(8'h06);
        a = 24'($urandom);
        key = 8'($urandom);
        cs_on;
        tx(32'h03, 8);
        tx(32'(a), 24);
        rx1(b, oor, oand);
        chk("rstmid_b0", 32'(b), 32'(a[7:0] ^ key));
        for (int i = 0; i < 3; i++) bitx(4'h0, q, o);
        rst = 1'b1;
        clks(1);
        chk("rstmid_dq_o", 32'(f_dq_o), 32'h0);
        chk("rstmid_oe", 32'(f_dq_oe), 32'h0);
        chk("rstmid_addr", 32'(mem_addr), 32'h0);
        chk("rstmid_strobes", 32'({mem_rd_en, mem_wr_en, mem_erase}), 32'h0);
        chk("rstmid_busy", 32'(busy), 32'h0);
        f_cs = 1'b1;
        clks(3);
        rst = 1'b0;
        clks(4);
        rdsr(b);
        chk("rstmid_sr", 32'(b), 32'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/qspi_flash_responder.md
# qspi_flash_responder

Synthesizable QSPI NOR-flash target that answers the flash controller's serial commands from the device side. It is used as an on-board flash emulator and loop-back target for controller bring-up. It oversamples the chip select, serial clock and DQ lines in the system clock domain, decodes a reduced command set, and maps reads, programs and erases onto a byte-wide memory port. Busy timing is modelled with programmable counters.

## Interface
Parameters:
- JEDEC_ID, 24'h20BA18: manufacturer/type/capacity bytes returned by 0x9F, MSB first.
- PROG_CYCLES, 1024: clk cycles that WIP stays set after a page-program commit.
- ERASE_CYCLES, 65536: clk cycles that WIP stays set after a sector-erase commit.

Ports:
- clk  in  1  system clock; must run at least 8× f_sclk.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- f_cs  in  1  chip select, active low, asynchronous to clk.
- f_sclk  in  1  serial clock, SPI mode 0, asynchronous to clk.
- f_dq_i  in  4  DQ3..DQ0 pad inputs.
- f_dq_o  out  4  DQ3..DQ0 pad outputs.
- f_dq_oe  out  4  per-line output enable, 1 = drive.
- mem_addr  out  24  byte address for the current read, write or erase.
- mem_rd_en  out  1  one-cycle read strobe.
- mem_rdata  in  8  read data, valid exactly 1 clk after mem_rd_en.
- mem_wr_en  out  1  one-cycle write strobe.
- mem_wdata  out  8  write byte.
- mem_erase  out  1  one-cycle 4 KB erase strobe. mem_addr = {addr[23:12], 12'h000}.
- busy  out  1  mirror of the WIP status bit.

## Operation
- **Input sync:** f_cs, f_sclk and f_dq_i each pass through a 2-FF synchronizer.
- **Edge detect:** rise/fall of f_sclk is detected on the synchronized copy.
  - Inputs are sampled on rise; outputs change on fall.
  - Bits are MSB first.
  - Quad nibbles map DQ3..DQ0 to bits 7..4, then 3..0.
- **Transaction start:** on the falling edge of synced f_cs, the FSM enters CMD and the bit counter clears.
- **FSM states:** IDLE, CMD, ADDR, DUMMY, RD_DATA, WR_DATA, STATUS, ID, IGNORE.
- **Commands** (decided after 8 single-line bits on DQ0):
  - 0x06 WREN: sets WEL at cs rise.
  - 0x04 WRDI: clears WEL at cs rise.
  - 0x05 RDSR → STATUS: shifts {6'b0, WEL, WIP} on DQ1, repeating every 8 clocks. The value is live, re-captured at each byte boundary.
  - 0x9F RDID → ID: 3 bytes on DQ1, then 0x00.
  - 0x03 READ → ADDR (24 bits, DQ0) → RD_DATA, single-line out on DQ1.
  - 0x6B quad output read → ADDR → DUMMY (8 sclk) → RD_DATA, quad out on DQ3..0.
  - 0x32 quad page program → ADDR → WR_DATA, quad in.
  - 0x20 4 KB sector erase → ADDR. Commits at cs rise only if exactly 32 bits have been received.
  - Any other opcode → IGNORE until cs rise.
- **Busy gating:** while WIP=1, every opcode except 0x05 goes to IGNORE. With WEL=0, 0x32 and 0x20 also go to IGNORE.
- **Reads:**
  - mem_rd_en pulses on the clk after the last address bit.
  - It pulses again each time the shift register loads a byte (prefetch of addr+1).
  - Address increments by 1 and wraps 0xFFFFFF→0x000000.
- **Program:**
  - Each completed byte pulses mem_wr_en with mem_addr = {base[23:8], ptr[7:0]}.
  - ptr wraps within the 256-byte page; upper bits never change.
  - Partial bytes at cs rise are discarded.
  - Bytes are written live. After cs rise, if ≥1 byte was written, WIP=1 and WEL=0.
- **Erase commit:** mem_erase pulses once, then WIP=1 and WEL=0.
- **WIP countdown:** a down-counter loaded with PROG_CYCLES or ERASE_CYCLES clears WIP at 0.
- **Output enables:**
  - f_dq_oe = 4'b0010 in STATUS, ID and single READ data.
  - f_dq_oe = 4'b1111 in quad RD_DATA.
  - Otherwise 0. Forced to 0 within 1 clk of synced cs rise.
- **cs rise in any state:** return to IDLE. Shift state is discarded. Status updates apply as above.

## Timing
- **Reset values:**
  - f_dq_o = 0, f_dq_oe = 0.
  - mem_addr = 0, mem_wdata = 0.
  - mem_rd_en = mem_wr_en = mem_erase = 0.
  - busy = 0, WEL = 0, FSM = IDLE.
- **Input latency:** pad to internal edge is 2 clk. Output data changes 1 clk after the detected sclk fall.
- **First read byte:** mem_rdata is captured 1 clk after mem_rd_en and must be loaded before the first data fall edge. This is guaranteed when clk ≥ 8× sclk.
- **Strobes:** mem_wr_en asserts 1 clk after the 8th bit's sampling edge (2nd nibble in quad).
- **Simultaneous events:** WREN issued while the WIP counter expires on the same clk has both effects applied.
- **Reset mid-transaction:** all state clears. No memory strobe is issued.

## Test plan
- RDID: cs low, send 0x9F, clock 32 bits → DQ1 returns 0x20, 0xBA, 0x18, 0x00; f_dq_oe = 0010 during data, 0 after cs rise.
- Program without WREN: 0x32 to addr 0x000100 with data 0xA5 → no mem_wr_en; RDSR reads 0x00.
- WREN, then 0x32 to addr 0x0001FE with 4 bytes 11,22,33,44 → writes to 0x1FE, 0x1FF, 0x100, 0x101. RDSR then reads 0x01 for PROG_CYCLES, followed by 0x00.
- Quad read: 0x6B to addr 0xFFFFFF with mem model returning addr[7:0] → nibbles give 0xFF, then 0x00. The mem_rd_en addresses are 0xFFFFFF, then 0x000000.
- Erase: WREN, 0x20 to 0x012345 → one mem_erase with mem_addr 0x012000, busy high. A 0x03 issued during busy returns no drive.
- Abort: cs rise after 20 address bits of 0x20 (WEL set) → no erase, WEL stays 1. Also assert rst mid-read → all outputs return to their reset values on the next clk.
